// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven initiator and a slave.
// The master modport drives the request channels; the slave modport drives
// the READYs and the response channels.
interface axi4lite_master_if #(
  parameter int addrWidth = 6,
  parameter int dataWidth = 32,
  parameter int strbWidth = 4
);
  logic [addrWidth-1:0] AWADDR;
  logic                 AWVALID;
  logic                 AWREADY;
  logic [dataWidth-1:0] WDATA;
  logic [strbWidth-1:0] WSTRB;
  logic                 WVALID;
  logic                 WREADY;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;
  logic [addrWidth-1:0] ARADDR;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [dataWidth-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator. Turns one valid/ready command into
// one AXI4-Lite write or read and reports the slave response on a one-cycle
// strobe. All bus outputs are registered except the state-decoded
// cmd_ready/BREADY/RREADY, so no VALID ever depends combinationally on a READY.
module axi4lite_master #(
  parameter int addrWidth = 6,
  parameter int dataWidth = 32,
  parameter int strbWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  input  logic [strbWidth-1:0] cmd_wstrb,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [1:0]           rsp_resp,
  output logic [dataWidth-1:0] rsp_rdata,
  axi4lite_master_if.master    axi
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQ,
    WRITE_RESP,
    READ_REQ,
    READ_RESP
  } state_t;

  state_t state;

  // AW and W complete independently; each flag remembers its handshake.
  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  assign aw_hs = axi.AWVALID && axi.AWREADY;
  assign w_hs  = axi.WVALID  && axi.WREADY;
  assign ar_hs = axi.ARVALID && axi.ARREADY;

  // Handshake enables are pure state decodes.
  assign cmd_ready  = (state == IDLE);
  assign axi.BREADY = (state == WRITE_RESP);
  assign axi.RREADY = (state == READ_RESP);

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.AWADDR  <= '0;
      axi.AWVALID <= 1'b0;
      axi.WDATA   <= '0;
      axi.WSTRB   <= '0;
      axi.WVALID  <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARVALID <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_resp    <= 2'b00;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              axi.AWADDR  <= cmd_addr;
              axi.WDATA   <= cmd_wdata;
              axi.WSTRB   <= cmd_wstrb;
              axi.AWVALID <= 1'b1;
              axi.WVALID  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WRITE_REQ;
            end else begin
              axi.ARADDR  <= cmd_addr;
              axi.ARVALID <= 1'b1;
              state       <= READ_REQ;
            end
          end
        end

        WRITE_REQ: begin
          if (aw_hs) begin
            axi.AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state <= WRITE_RESP;
          end
        end

        WRITE_RESP: begin
          if (axi.BVALID) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_resp  <= axi.BRESP;
            rsp_rdata <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            state     <= IDLE;
          end
        end

        READ_REQ: begin
          if (ar_hs) begin
            axi.ARVALID <= 1'b0;
            state       <= READ_RESP;
          end
        end

        READ_RESP: begin
          if (axi.RVALID) begin
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_resp  <= axi.RRESP;
            rsp_rdata <= axi.RDATA;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master with a small memory-backed slave model
// whose READY delays and read response can be steered from the stimulus.
module tb_axi4lite_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_write;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;

  axi4lite_master_if #(.addrWidth(6), .dataWidth(32), .strbWidth(4)) bus ();

  axi4lite_master #(.addrWidth(6), .dataWidth(32), .strbWidth(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_resp  (rsp_resp),
    .rsp_rdata (rsp_rdata),
    .axi       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave knobs driven by the stimulus.
  int          aw_cfg;
  int          ar_cfg;
  logic        force_r;
  logic [31:0] force_rdata;
  logic [1:0]  force_rresp;
  logic        stray_b;

  // Slave model state.
  int          aw_wait;
  int          ar_wait;
  logic        aw_got;
  logic        w_got;
  logic [5:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] mem [16];
  logic        a_ok;
  logic        w_ok;
  logic [5:0]  waddr;
  logic [31:0] wdat;
  logic [3:0]  wstb;

  assign bus.AWREADY = (aw_wait >= aw_cfg);
  assign bus.WREADY  = 1'b1;
  assign bus.ARREADY = (ar_wait >= ar_cfg);
  assign bus.BVALID  = bvalid_q | stray_b;
  assign bus.BRESP   = 2'b00;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;

  always @(posedge clk) begin
    if (reset) begin
      aw_wait  <= 0;
      ar_wait  <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (!bus.AWVALID || bus.AWREADY) aw_wait <= 0;
      else aw_wait <= aw_wait + 1;
      if (!bus.ARVALID || bus.ARREADY) ar_wait <= 0;
      else ar_wait <= ar_wait + 1;

      a_ok  = aw_got || (bus.AWVALID && bus.AWREADY);
      w_ok  = w_got  || (bus.WVALID && bus.WREADY);
      waddr = aw_got ? aw_addr_q : bus.AWADDR;
      wdat  = w_got ? w_data_q : bus.WDATA;
      wstb  = w_got ? w_strb_q : bus.WSTRB;

      if (bus.AWVALID && bus.AWREADY) aw_addr_q <= bus.AWADDR;
      if (bus.WVALID && bus.WREADY) begin
        w_data_q <= bus.WDATA;
        w_strb_q <= bus.WSTRB;
      end

      if (a_ok && w_ok && !bvalid_q) begin
        for (int b = 0; b < 4; b++)
          if (wstb[b]) mem[waddr[5:2]][8*b +: 8] <= wdat[8*b +: 8];
        bvalid_q <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (bus.AWVALID && bus.AWREADY) aw_got <= 1'b1;
        if (bus.WVALID && bus.WREADY) w_got <= 1'b1;
        if (bvalid_q && bus.BREADY) bvalid_q <= 1'b0;
      end

      if (bus.ARVALID && bus.ARREADY) begin
        rvalid_q <= 1'b1;
        rdata_q  <= force_r ? force_rdata : mem[bus.ARADDR[5:2]];
        rresp_q  <= force_r ? force_rresp : 2'b00;
      end else if (rvalid_q && bus.RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cmd_wstrb   = '0;
    aw_cfg      = 0;
    ar_cfg      = 0;
    force_r     = 1'b0;
    force_rdata = '0;
    force_rresp = 2'b00;
    stray_b     = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_awvalid",   32'(bus.AWVALID), 32'd0);
    chk("rst_wvalid",    32'(bus.WVALID), 32'd0);
    chk("rst_arvalid",   32'(bus.ARVALID), 32'd0);
    chk("rst_bready",    32'(bus.BREADY), 32'd0);
    chk("rst_rready",    32'(bus.RREADY), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_resp",  32'(rsp_resp), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_awaddr",    32'(bus.AWADDR), 32'd0);
    chk("rst_wdata",     bus.WDATA, 32'd0);
    reset = 1'b0;
    tick();

    // Write, zero-wait slave: accepted at edge N
    set_cmd(1'b1, 6'd12, 32'hAA00CCC3, 4'b1011);
    chk("w_cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("w_awvalid_n1", 32'(bus.AWVALID), 32'd1);
    chk("w_wvalid_n1",  32'(bus.WVALID), 32'd1);
    chk("w_awaddr_n1",  32'(bus.AWADDR), 32'd12);
    chk("w_wdata_n1",   bus.WDATA, 32'hAA00CCC3);
    chk("w_wstrb_n1",   32'(bus.WSTRB), 32'hB);
    chk("w_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    tick();
    chk("w_awvalid_n2", 32'(bus.AWVALID), 32'd0);
    chk("w_bready_n2",  32'(bus.BREADY), 32'd1);
    chk("w_rsp_n2",     32'(rsp_valid), 32'd0);
    tick();
    chk("w_rsp_valid_n3", 32'(rsp_valid), 32'd1);
    chk("w_rsp_write_n3", 32'(rsp_write), 32'd1);
    chk("w_rsp_resp_n3",  32'(rsp_resp), 32'd0);
    chk("w_rsp_rdata_n3", rsp_rdata, 32'd0);
    chk("w_cmd_ready_n3", 32'(cmd_ready), 32'd1);
    tick();
    chk("w_rsp_drop", 32'(rsp_valid), 32'd0);

    // Read-back of address 12
    set_cmd(1'b0, 6'd12, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("r_arvalid_n1", 32'(bus.ARVALID), 32'd1);
    chk("r_araddr_n1",  32'(bus.ARADDR), 32'd12);
    tick();
    chk("r_rready_n2",  32'(bus.RREADY), 32'd1);
    chk("r_arvalid_n2", 32'(bus.ARVALID), 32'd0);
    tick();
    chk("r_rsp_valid_n3", 32'(rsp_valid), 32'd1);
    chk("r_rsp_write_n3", 32'(rsp_write), 32'd0);
    chk("r_rsp_rdata_n3", rsp_rdata, 32'hAA00CCC3);
    chk("r_rsp_resp_n3",  32'(rsp_resp), 32'd0);
    tick();

    // Single-byte write into byte 2, then read back the merged word
    set_cmd(1'b1, 6'd12, 32'hFFFFFFFF, 4'b0100);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("m_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    set_cmd(1'b0, 6'd12, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("m_rdata", rsp_rdata, 32'hAAFFCCC3);

    // Split handshakes: W accepted at once, AW held off three cycles
    tick();
    aw_cfg = 3;
    set_cmd(1'b1, 6'd8, 32'h0BADF00D, 4'b1111);
    tick();
    cmd_valid = 1'b0;
    chk("s_awvalid_n1", 32'(bus.AWVALID), 32'd1);
    chk("s_wvalid_n1",  32'(bus.WVALID), 32'd1);
    tick();
    chk("s_wvalid_n2",  32'(bus.WVALID), 32'd0);
    chk("s_awvalid_n2", 32'(bus.AWVALID), 32'd1);
    chk("s_awaddr_n2",  32'(bus.AWADDR), 32'd8);
    tick();
    chk("s_awvalid_n3", 32'(bus.AWVALID), 32'd1);
    chk("s_bready_n3",  32'(bus.BREADY), 32'd0);
    tick();
    chk("s_awvalid_n4", 32'(bus.AWVALID), 32'd1);
    chk("s_awaddr_n4",  32'(bus.AWADDR), 32'd8);
    chk("s_bready_n4",  32'(bus.BREADY), 32'd0);
    tick();
    chk("s_awvalid_n5", 32'(bus.AWVALID), 32'd0);
    chk("s_bready_n5",  32'(bus.BREADY), 32'd1);
    tick();
    chk("s_rsp_valid_n6", 32'(rsp_valid), 32'd1);
    chk("s_rsp_write_n6", 32'(rsp_write), 32'd1);
    aw_cfg = 0;
    tick();

    // Error response on a read
    force_r     = 1'b1;
    force_rdata = 32'hDEADBEEF;
    force_rresp = 2'b10;
    set_cmd(1'b0, 6'd4, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("e_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("e_rsp_resp",  32'(rsp_resp), 32'd2);
    chk("e_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("e_rsp_write", 32'(rsp_write), 32'd0);
    tick();
    chk("e_rsp_single", 32'(rsp_valid), 32'd0);
    force_r = 1'b0;

    // Back-to-back: write held valid while a read is in flight
    set_cmd(1'b0, 6'd8, 32'd0, 4'd0);
    tick();
    set_cmd(1'b1, 6'd20, 32'h12345678, 4'b1111);
    chk("b_cmd_ready_n1", 32'(cmd_ready), 32'd0);
    chk("b_arvalid_n1",   32'(bus.ARVALID), 32'd1);
    tick();
    stray_b = 1'b1;
    chk("b_bready_in_read", 32'(bus.BREADY), 32'd0);
    chk("b_awvalid_n2",     32'(bus.AWVALID), 32'd0);
    tick();
    stray_b = 1'b0;
    chk("b_rsp_valid_n3", 32'(rsp_valid), 32'd1);
    chk("b_rsp_write_n3", 32'(rsp_write), 32'd0);
    chk("b_rsp_rdata_n3", rsp_rdata, 32'h0BADF00D);
    chk("b_cmd_ready_n3", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("b2_awvalid", 32'(bus.AWVALID), 32'd1);
    chk("b2_awaddr",  32'(bus.AWADDR), 32'd20);
    chk("b2_wdata",   bus.WDATA, 32'h12345678);
    chk("b2_rsp_off", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    chk("b2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2_rsp_write", 32'(rsp_write), 32'd1);
    tick();
    set_cmd(1'b0, 6'd20, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("b2_readback", rsp_rdata, 32'h12345678);
    tick();

    // Reset while ARVALID waits for ARREADY
    ar_cfg = 10;
    set_cmd(1'b0, 6'd16, 32'd0, 4'd0);
    tick();
    cmd_valid = 1'b0;
    chk("x_arvalid_n1", 32'(bus.ARVALID), 32'd1);
    chk("x_araddr_n1",  32'(bus.ARADDR), 32'd16);
    tick();
    chk("x_arvalid_n2", 32'(bus.ARVALID), 32'd1);
    chk("x_araddr_n2",  32'(bus.ARADDR), 32'd16);
    reset = 1'b1;
    tick();
    chk("x_arvalid_rst",  32'(bus.ARVALID), 32'd0);
    chk("x_cmd_ready",    32'(cmd_ready), 32'd1);
    chk("x_rsp_valid",    32'(rsp_valid), 32'd0);
    chk("x_araddr_rst",   32'(bus.ARADDR), 32'd0);
    chk("x_rready_rst",   32'(bus.RREADY), 32'd0);
    reset  = 1'b0;
    ar_cfg = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("x_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
